// File: rtl/uart8_tx_queue_pkg.sv
// -----------------------------------------------------------------------------
// uart8_tx_queue_pkg
// Shared definitions for the Uart8 transmit queue:
//   - state_t : launch sequencer states (IDLE, START, SEND)
//   - f_clog2 : ceiling log2, used to size counters from parameters
// -----------------------------------------------------------------------------
package uart8_tx_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  // Ceiling log2 of a positive integer; returns 0 for values <= 1.
  function automatic int f_clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart8_byte_fifo.sv
// -----------------------------------------------------------------------------
// uart8_byte_fifo
// Byte-wide synchronous FIFO with registered count and full/empty flags.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset (flushes the queue)
//   i_push, i_data : write request and byte; ignored while full
//   i_pop          : read request; ignored while empty
//   o_head         : byte at the read pointer (valid when !o_empty)
//   o_count        : bytes held (ADDR_WIDTH+1 bits)
//   o_full/o_empty : registered status flags
// -----------------------------------------------------------------------------
module uart8_byte_fifo
  import uart8_tx_queue_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [7:0]            i_data,
  input  logic                  i_pop,
  output logic [7:0]            o_head,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1'b1);
  localparam logic [ADDR_WIDTH:0]   COUNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1'b1);

  logic [7:0]            r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;

  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // Full blocks a push even when a pop happens in the same cycle, so the
  // accept decision depends only on registered state.
  assign w_push_ok = i_push && !r_full;
  assign w_pop_ok  = i_pop && !r_empty;

  // Next occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + COUNT_ONE;
      2'b01:   w_count_nxt = r_count - COUNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array; contents need no reset because pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, count and flags; pointers wrap naturally mod DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= {ADDR_WIDTH{1'b0}};
      r_rd_ptr <= {ADDR_WIDTH{1'b0}};
      r_count  <= {(ADDR_WIDTH + 1){1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == COUNT_MAX);
      r_empty <= (w_count_nxt == {(ADDR_WIDTH + 1){1'b0}});
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/uart8_tx_queue.sv
// -----------------------------------------------------------------------------
// uart8_tx_queue
// Byte queue plus launch sequencer feeding the Uart8 transmitter. System logic
// pushes bytes on a valid/ready handshake; the sequencer presents one byte at a
// time on txEn/txStart/txData, holds txStart until the transmitter's busy flag
// is seen, then waits for the frame to end.
// Ports:
//   i_clk, i_reset   : board clock, synchronous active-high reset
//   i_enable         : allow launching new frames (sampled only in IDLE)
//   i_in_valid/data  : byte offered for queuing
//   o_in_ready       : queue can accept (not full)
//   o_count          : bytes held, excluding the byte being launched
//   o_tx_en/start    : to Uart8 txEn / txStart
//   o_tx_data        : to Uart8 data input, stable while o_tx_start is high
//   i_tx_busy        : Uart8 busy flag from the transmit clock domain
//   o_sent           : one-cycle pulse per completed frame
//   o_timeout_err    : one-cycle pulse when a byte is abandoned
// -----------------------------------------------------------------------------
module uart8_tx_queue
  import uart8_tx_queue_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = 4,
  parameter int START_TIMEOUT = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_in_valid,
  input  logic [7:0]            i_in_data,
  output logic                  o_in_ready,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_tx_en,
  output logic                  o_tx_start,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_busy,
  output logic                  o_sent,
  output logic                  o_timeout_err
);

  localparam int TIMER_WIDTH = (f_clog2(START_TIMEOUT) < 1) ? 1 : f_clog2(START_TIMEOUT);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(START_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = TIMER_WIDTH'(1'b1);

  // Busy synchroniser
  logic                   r_busy_meta;
  logic                   r_busy_s;

  // Sequencer state and registered outputs
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic [TIMER_WIDTH-1:0] w_timer_nxt;
  logic                   r_tx_en;
  logic                   w_tx_en_nxt;
  logic                   r_tx_start;
  logic                   w_tx_start_nxt;
  logic [7:0]             r_tx_data;
  logic [7:0]             w_tx_data_nxt;
  logic                   r_sent;
  logic                   w_sent_nxt;
  logic                   r_timeout_err;
  logic                   w_timeout_err_nxt;

  // FIFO interface
  logic                   w_pop;
  logic                   w_push;
  logic [7:0]             w_head;
  logic [ADDR_WIDTH:0]    w_count;
  logic                   w_full;
  logic                   w_empty;

  assign w_push = i_in_valid && !w_full;

  uart8_byte_fifo #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  (i_in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Two-flop synchroniser for the transmitter busy flag. It is deliberately
  // left out of reset: after a reset mid-frame it must keep tracking the
  // still-running transmitter so IDLE does not launch into a busy Uart8.
  always_ff @(posedge i_clk) begin
    r_busy_meta <= i_tx_busy;
    r_busy_s    <= r_busy_meta;
  end

  // Sequencer next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_timer_nxt       = r_timer;
    w_tx_en_nxt       = r_tx_en;
    w_tx_start_nxt    = r_tx_start;
    w_tx_data_nxt     = r_tx_data;
    w_sent_nxt        = 1'b0;
    w_timeout_err_nxt = 1'b0;
    w_pop             = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = {TIMER_WIDTH{1'b0}};
        // !busy guard keeps us from launching while a frame started before
        // a reset is still on the line.
        if (i_enable && !w_empty && !r_busy_s) begin
          w_pop          = 1'b1;
          w_tx_data_nxt  = w_head;
          w_tx_start_nxt = 1'b1;
          w_tx_en_nxt    = 1'b1;
          w_state_nxt    = ST_START;
        end else begin
          w_tx_start_nxt = 1'b0;
          w_tx_en_nxt    = i_enable;
        end
      end

      ST_START: begin
        if (r_busy_s) begin
          w_tx_start_nxt = 1'b0;
          w_tx_en_nxt    = 1'b1;
          w_timer_nxt    = {TIMER_WIDTH{1'b0}};
          w_state_nxt    = ST_SEND;
        end else if (r_timer == TIMER_LAST) begin
          // Transmitter never acknowledged: drop the byte and report it.
          w_tx_start_nxt    = 1'b0;
          w_timeout_err_nxt = 1'b1;
          w_tx_en_nxt       = i_enable;
          w_timer_nxt       = {TIMER_WIDTH{1'b0}};
          w_state_nxt       = ST_IDLE;
        end else begin
          w_tx_start_nxt = 1'b1;
          w_tx_en_nxt    = 1'b1;
          w_timer_nxt    = r_timer + TIMER_ONE;
        end
      end

      ST_SEND: begin
        w_tx_start_nxt = 1'b0;
        if (!r_busy_s) begin
          // enable is only honoured here, once the frame has fully ended.
          w_sent_nxt  = 1'b1;
          w_tx_en_nxt = i_enable;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tx_en_nxt = 1'b1;
        end
      end

      default: begin
        w_tx_start_nxt = 1'b0;
        w_tx_en_nxt    = 1'b0;
        w_timer_nxt    = {TIMER_WIDTH{1'b0}};
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, timer and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_timer       <= {TIMER_WIDTH{1'b0}};
      r_tx_en       <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_sent        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_tx_en       <= w_tx_en_nxt;
      r_tx_start    <= w_tx_start_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_sent        <= w_sent_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign o_in_ready    = !w_full;
  assign o_count       = w_count;
  assign o_tx_en       = r_tx_en;
  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_sent        = r_sent;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart8_tx_queue.sv
// -----------------------------------------------------------------------------
// tb_uart8_tx_queue
// Directed bench for uart8_tx_queue (DEPTH=16, START_TIMEOUT=8). A transmitter
// model raises txBusy 3 clk after it sees txStart and holds it for 40 clk.
// -----------------------------------------------------------------------------
module tb_uart8_tx_queue;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [4:0] count;
  logic       tx_en;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       sent;
  logic       timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // transmitter model control / observations
  bit model_on = 1'b1;
  int busy_rise_cyc = 0;
  int busy_fall_cyc = 0;

  // monitor observations
  logic [7:0] launch_q[$];
  int start_rise_cyc  = 0;
  int start_fall_cyc  = 0;
  int sent_hi         = 0;
  int sent_rise       = 0;
  int last_sent_cyc   = -1;
  int to_hi           = 0;
  int to_rise         = 0;
  int busy_violations = 0;
  int min_gap         = 1000;
  logic bs1 = 1'b0;
  logic bs2 = 1'b0;

  uart8_tx_queue #(
    .DEPTH         (16),
    .ADDR_WIDTH    (4),
    .START_TIMEOUT (8)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_enable      (enable),
    .i_in_valid    (in_valid),
    .i_in_data     (in_data),
    .o_in_ready    (in_ready),
    .o_count       (count),
    .o_tx_en       (tx_en),
    .o_tx_start    (tx_start),
    .o_tx_data     (tx_data),
    .i_tx_busy     (tx_busy),
    .o_sent        (sent),
    .o_timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bs1 <= tx_busy;
    bs2 <= bs1;
  end

  // Transmitter model: drives at #2 after the edge so #1 samples see old value.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (model_on && tx_start) begin
        repeat (3) @(posedge clk);
        #2; tx_busy = 1'b1; busy_rise_cyc = cyc;
        repeat (40) @(posedge clk);
        #2; tx_busy = 1'b0; busy_fall_cyc = cyc;
      end
    end
  end

  // Event monitor on the falling edge.
  initial begin
    logic start_q, sent_q, to_q, bs_prev;
    start_q = 1'b0; sent_q = 1'b0; to_q = 1'b0; bs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !start_q) begin
        launch_q.push_back(tx_data);
        start_rise_cyc = cyc;
        if (bs_prev) busy_violations++;
        if (last_sent_cyc >= 0 && (cyc - last_sent_cyc) < min_gap) min_gap = cyc - last_sent_cyc;
      end
      if (!tx_start && start_q) start_fall_cyc = cyc;
      if (sent) begin
        sent_hi++;
        if (!sent_q) begin sent_rise++; last_sent_cyc = cyc; end
      end
      if (timeout_err) begin
        to_hi++;
        if (!to_q) to_rise++;
      end
      start_q = tx_start; sent_q = sent; to_q = timeout_err; bs_prev = bs2;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic bit cond_met(input int which, input int target);
    case (which)
      0:       return sent_rise >= target;
      1:       return launch_q.size() >= target;
      2:       return to_rise >= target;
      3:       return tx_start == 1'b0;
      default: return tx_busy == 1'b0;
    endcase
  endfunction

  // Bounded wait: 0=sent pulses, 1=launches, 2=timeouts, 3=txStart low, 4=txBusy low.
  task automatic wait_for(input int which, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (cond_met(which, target)) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok && cond_met(which, target)) ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (4) tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else n_pass++;
    n_checks++; if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (tx_en !== 1'b0) $display("FAIL reset_tx_en: got %0b want 0", tx_en); else n_pass++;
    n_checks++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %0b want 0", tx_start); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %0h want 00", tx_data); else n_pass++;
    n_checks++; if (sent !== 1'b0) $display("FAIL reset_sent: got %0b want 0", sent); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout: got %0b want 0", timeout_err); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_byte();
    bit ok;
    int s0;
    s0 = sent_rise;
    enable = 1'b1;
    push(8'hA5);
    n_checks++; if (count !== 5'd1) $display("FAIL single_count_pushed: got %0d want 1", count); else n_pass++;
    tick();
    n_checks++; if (tx_start !== 1'b1) $display("FAIL single_tx_start: got %0b want 1", tx_start); else n_pass++;
    n_checks++; if (tx_data !== 8'hA5) $display("FAIL single_tx_data: got %0h want a5", tx_data); else n_pass++;
    n_checks++; if (tx_en !== 1'b1) $display("FAIL single_tx_en: got %0b want 1", tx_en); else n_pass++;
    n_checks++; if (count !== 5'd0) $display("FAIL single_count_popped: got %0d want 0", count); else n_pass++;
    wait_for(0, s0 + 1, 80, ok);
    n_checks++; if (!ok) $display("FAIL single_sent_wait: got timeout want sent pulse"); else n_pass++;
    // busy driven after edge B: sampled at B+1, busyS at B+2, txStart low at B+3
    n_checks++; if (start_fall_cyc - busy_rise_cyc !== 3) $display("FAIL single_start_drop: got %0d want 3", start_fall_cyc - busy_rise_cyc); else n_pass++;
    n_checks++; if (last_sent_cyc - busy_fall_cyc !== 3) $display("FAIL single_sent_lat: got %0d want 3", last_sent_cyc - busy_fall_cyc); else n_pass++;
    n_checks++; if (sent !== 1'b0) $display("FAIL single_sent_width: got %0b want 0", sent); else n_pass++;
    n_checks++; if (count !== 5'd0) $display("FAIL single_count_end: got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_fill_overflow();
    logic       ready16;
    logic [4:0] count16;
    int         l0;
    ready16 = 1'b1; count16 = 5'd0;
    enable = 1'b0;
    tick();
    l0 = launch_q.size();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      if (i == 15) begin ready16 = in_ready; count16 = count; end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (ready16 !== 1'b0) $display("FAIL fill_ready_after16: got %0b want 0", ready16); else n_pass++;
    n_checks++; if (count16 !== 5'd16) $display("FAIL fill_count_after16: got %0d want 16", count16); else n_pass++;
    n_checks++; if (count !== 5'd16) $display("FAIL fill_count_final: got %0d want 16", count); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL fill_ready_final: got %0b want 0", in_ready); else n_pass++;
    n_checks++; if (tx_en !== 1'b0) $display("FAIL fill_tx_en: got %0b want 0", tx_en); else n_pass++;
    n_checks++; if (launch_q.size() !== l0) $display("FAIL fill_no_launch: got %0d want %0d", launch_q.size(), l0); else n_pass++;
  endtask

  task automatic test_drain();
    bit ok;
    int l0, s0, sh0;
    l0 = launch_q.size(); s0 = sent_rise; sh0 = sent_hi;
    min_gap = 1000;
    // enable and a push offer in the same cycle: the pop happens but the
    // full queue still refuses 0xEE
    enable = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    tick();
    in_valid = 1'b0;
    n_checks++; if (count !== 5'd15) $display("FAIL drain_full_push_refused: got %0d want 15", count); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL drain_ready: got %0b want 1", in_ready); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL drain_first_data: got %0h want 00", tx_data); else n_pass++;
    wait_for(0, s0 + 16, 1200, ok);
    n_checks++; if (!ok) $display("FAIL drain_sent_wait: got %0d want %0d", sent_rise - s0, 16); else n_pass++;
    tick(); tick();
    n_checks++; if (launch_q.size() - l0 !== 16) $display("FAIL drain_launch_count: got %0d want 16", launch_q.size() - l0); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      if (l0 + i < launch_q.size()) begin
        n_checks++; if (launch_q[l0 + i] !== 8'(i)) $display("FAIL drain_order[%0d]: got %0h want %0h", i, launch_q[l0 + i], i); else n_pass++;
      end
    end
    n_checks++; if (sent_rise - s0 !== 16) $display("FAIL drain_sent_count: got %0d want 16", sent_rise - s0); else n_pass++;
    n_checks++; if (sent_hi - sh0 !== 16) $display("FAIL drain_sent_width: got %0d want 16", sent_hi - sh0); else n_pass++;
    n_checks++; if (busy_violations !== 0) $display("FAIL drain_start_while_busy: got %0d want 0", busy_violations); else n_pass++;
    n_checks++; if (min_gap !== 1) $display("FAIL drain_b2b_gap: got %0d want 1", min_gap); else n_pass++;
    n_checks++; if (count !== 5'd0) $display("FAIL drain_count: got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    int s0, t0, th0;
    s0 = sent_rise; t0 = to_rise; th0 = to_hi;
    model_on = 1'b0;
    push(8'h3C);
    wait_for(2, t0 + 1, 30, ok);
    n_checks++; if (!ok) $display("FAIL timeout_wait: got no pulse want pulse"); else n_pass++;
    tick();
    n_checks++; if (start_fall_cyc - start_rise_cyc !== 8) $display("FAIL timeout_start_len: got %0d want 8", start_fall_cyc - start_rise_cyc); else n_pass++;
    n_checks++; if (launch_q[$] !== 8'h3C) $display("FAIL timeout_data: got %0h want 3c", launch_q[$]); else n_pass++;
    n_checks++; if (to_hi - th0 !== 1) $display("FAIL timeout_pulse_width: got %0d want 1", to_hi - th0); else n_pass++;
    n_checks++; if (sent_rise !== s0) $display("FAIL timeout_no_sent: got %0d want %0d", sent_rise, s0); else n_pass++;
    n_checks++; if (tx_start !== 1'b0 || tx_en !== 1'b1) $display("FAIL timeout_idle: got start=%0b en=%0b want start=0 en=1", tx_start, tx_en); else n_pass++;
    n_checks++; if (count !== 5'd0) $display("FAIL timeout_count: got %0d want 0", count); else n_pass++;
    model_on = 1'b1;
  endtask

  task automatic test_enable_drop();
    bit ok;
    int s0, l0;
    s0 = sent_rise;
    enable = 1'b1;
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    in_valid = 1'b0;
    // 0x11 popped while 0x22 pushed in the same cycle
    n_checks++; if (count !== 5'd1) $display("FAIL endrop_push_pop_count: got %0d want 1", count); else n_pass++;
    n_checks++; if (tx_data !== 8'h11) $display("FAIL endrop_first_data: got %0h want 11", tx_data); else n_pass++;
    wait_for(3, 0, 20, ok);
    n_checks++; if (!ok) $display("FAIL endrop_send_wait: got start high want low"); else n_pass++;
    enable = 1'b0;
    wait_for(0, s0 + 1, 80, ok);
    n_checks++; if (!ok) $display("FAIL endrop_sent_wait: got no sent want sent"); else n_pass++;
    l0 = launch_q.size();
    n_checks++; if (tx_en !== 1'b0) $display("FAIL endrop_tx_en: got %0b want 0", tx_en); else n_pass++;
    repeat (20) tick();
    n_checks++; if (launch_q.size() !== l0) $display("FAIL endrop_retained: got %0d launches want %0d", launch_q.size(), l0); else n_pass++;
    n_checks++; if (count !== 5'd1) $display("FAIL endrop_count: got %0d want 1", count); else n_pass++;
    enable = 1'b1;
    wait_for(1, l0 + 1, 10, ok);
    n_checks++; if (!ok || launch_q[$] !== 8'h22) $display("FAIL endrop_resume: got %0h want 22", launch_q[$]); else n_pass++;
    wait_for(0, s0 + 2, 80, ok);
    n_checks++; if (!ok || count !== 5'd0) $display("FAIL endrop_final: got count=%0d want 0", count); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int s0, l0;
    enable = 1'b1;
    l0 = launch_q.size();
    push(8'h55);
    wait_for(1, l0 + 1, 10, ok);
    wait_for(3, 0, 20, ok);
    n_checks++; if (!ok) $display("FAIL rst_send_wait: got start high want low"); else n_pass++;
    repeat (17) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (tx_start !== 1'b0 || tx_en !== 1'b0 || count !== 5'd0) $display("FAIL rst_mid_state: got start=%0b en=%0b count=%0d want 0/0/0", tx_start, tx_en, count); else n_pass++;
    n_checks++; if (tx_busy !== 1'b1) $display("FAIL rst_busy_still_high: got %0b want 1", tx_busy); else n_pass++;
    s0 = sent_rise;
    l0 = launch_q.size();
    push(8'h77);
    n_checks++; if (count !== 5'd1) $display("FAIL rst_push_count: got %0d want 1", count); else n_pass++;
    wait_for(4, 0, 60, ok);
    n_checks++; if (!ok) $display("FAIL rst_busy_wait: got busy high want low"); else n_pass++;
    n_checks++; if (launch_q.size() !== l0 || count !== 5'd1) $display("FAIL rst_no_early_launch: got launches=%0d count=%0d want %0d/1", launch_q.size(), count, l0); else n_pass++;
    wait_for(1, l0 + 1, 20, ok);
    n_checks++; if (!ok || launch_q[$] !== 8'h77) $display("FAIL rst_launch_data: got %0h want 77", launch_q[$]); else n_pass++;
    // busy low driven after edge F: busyS low at F+2, launch at F+3
    n_checks++; if (start_rise_cyc - busy_fall_cyc !== 3) $display("FAIL rst_launch_lat: got %0d want 3", start_rise_cyc - busy_fall_cyc); else n_pass++;
    wait_for(0, s0 + 1, 80, ok);
    n_checks++; if (!ok || sent_rise - s0 !== 1) $display("FAIL rst_final_sent: got %0d want 1", sent_rise - s0); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_drain();
    test_timeout();
    test_enable_drop();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
